// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM (lw/sw/R-type/beq/j/addi)
module mips_multicycle_ctrl #(
    parameter logic ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic [3:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_IEX    = 4'd10,
        S_IWB    = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_MUL = 4'b0011;
    localparam logic [3:0] ALU_DIV = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    state_t state_q, state_d;

    logic pc_write_c, mem_read_c, mem_write_c, ir_write_c;
    logic reg_write_c, instr_done_c, illegal_op_c;
    logic opcode_legal;

    always_comb begin
        opcode_legal = 1'b0;
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: opcode_legal = 1'b1;
            default: opcode_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_REX;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_IEX;
                    default:      state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_REX:    state_d = S_RWB;
            S_IEX:    state_d = S_IWB;
            S_MEMWB, S_RWB, S_BEQ, S_JUMP, S_IWB: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
        // Reset wins over everything, including HALT and memory stalls.
        if (rst) state_d = S_FETCH;
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    always_comb begin
        alu_control  = 4'b0000;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        pc_source    = 2'b00;
        iord         = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        pc_write_c   = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        instr_done_c = 1'b0;
        illegal_op_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
                ir_write_c  = mem_ready;
                pc_write_c  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b    = 2'b11;
                alu_control  = ALU_ADD;
                illegal_op_c = ~opcode_legal;
            end
            S_MEMADR, S_IEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                mem_read_c = 1'b1;
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg   = 1'b1;
                instr_done_c = 1'b1;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                mem_write_c  = 1'b1;
                instr_done_c = mem_ready;
            end
            S_REX: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'h20:   alu_control = ALU_ADD;
                    6'h22:   alu_control = ALU_SUB;
                    6'h18:   alu_control = ALU_MUL;
                    6'h1A:   alu_control = ALU_DIV;
                    6'h24:   alu_control = ALU_AND;
                    6'h25:   alu_control = ALU_OR;
                    6'h2A:   alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            S_RWB: begin
                reg_write_c  = 1'b1;
                reg_dst      = 1'b1;
                instr_done_c = 1'b1;
            end
            S_BEQ: begin
                alu_src_a    = 1'b1;
                alu_control  = ALU_SUB;
                pc_source    = 2'b01;
                pc_write_c   = alu_zero;
                instr_done_c = 1'b1;
            end
            S_JUMP: begin
                pc_source    = 2'b10;
                pc_write_c   = 1'b1;
                instr_done_c = 1'b1;
            end
            S_IWB: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_write   = pc_write_c   & ~rst;
    assign mem_read   = mem_read_c   & ~rst;
    assign mem_write  = mem_write_c  & ~rst;
    assign ir_write   = ir_write_c   & ~rst;
    assign reg_write  = reg_write_c  & ~rst;
    assign instr_done = instr_done_c & ~rst;
    assign illegal_op = illegal_op_c & ~rst;
    assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed + random check of mips_multicycle_ctrl against an instruction-level model
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic [3:0] alu0, alu1, st0, st1;
    logic       sa0, sa1, pw0, pw1, io0, io1, mr0, mr1, mw0, mw1, ir0, ir1;
    logic       rw0, rw1, rd0, rd1, m2r0, m2r1, dn0, dn1, il0, il1;
    logic [1:0] sb0, sb1, ps0, ps1;
    logic [18:0] o0, o1;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    localparam logic [18:0] SMASK = 19'b0000_0_00_1_00_0_1_1_1_1_0_0_1_1;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .alu_control(alu0), .alu_src_a(sa0), .alu_src_b(sb0),
        .pc_write(pw0), .pc_source(ps0), .iord(io0), .mem_read(mr0), .mem_write(mw0),
        .ir_write(ir0), .reg_write(rw0), .reg_dst(rd0), .mem_to_reg(m2r0),
        .instr_done(dn0), .illegal_op(il0), .state(st0)
    );

    mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .alu_control(alu1), .alu_src_a(sa1), .alu_src_b(sb1),
        .pc_write(pw1), .pc_source(ps1), .iord(io1), .mem_read(mr1), .mem_write(mw1),
        .ir_write(ir1), .reg_write(rw1), .reg_dst(rd1), .mem_to_reg(m2r1),
        .instr_done(dn1), .illegal_op(il1), .state(st1)
    );

    assign o0 = {alu0, sa0, sb0, pw0, ps0, io0, mr0, mw0, ir0, rw0, rd0, m2r0, dn0, il0};
    assign o1 = {alu1, sa1, sb1, pw1, ps1, io1, mr1, mw1, ir1, rw1, rd1, m2r1, dn1, il1};

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [3:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'h20: return 4'b0010;
            6'h22: return 4'b0110;
            6'h18: return 4'b0011;
            6'h1A: return 4'b0100;
            6'h24: return 4'b0000;
            6'h25: return 4'b0001;
            6'h2A: return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    // Output table per state, straight from the state descriptions.
    function automatic logic [18:0] exp_out(input logic [3:0] s, input logic mrdy,
                                            input logic az, input logic [5:0] op,
                                            input logic [5:0] fn);
        logic [3:0] alu = 4'b0000;
        logic       sa = 1'b0, pw = 1'b0, io = 1'b0, mrd = 1'b0, mwr = 1'b0, irw = 1'b0;
        logic       rw = 1'b0, rd = 1'b0, m2r = 1'b0, dn = 1'b0, ill = 1'b0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        case (s)
            4'd0:  begin mrd = 1; sb = 2'b01; alu = 4'b0010; irw = mrdy; pw = mrdy; end
            4'd1:  begin sb = 2'b11; alu = 4'b0010;
                         ill = !(op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08}); end
            4'd2:  begin sa = 1; sb = 2'b10; alu = 4'b0010; end
            4'd3:  begin io = 1; mrd = 1; end
            4'd4:  begin rw = 1; m2r = 1; dn = 1; end
            4'd5:  begin io = 1; mwr = 1; dn = mrdy; end
            4'd6:  begin sa = 1; alu = funct_alu(fn); end
            4'd7:  begin rw = 1; rd = 1; dn = 1; end
            4'd8:  begin sa = 1; alu = 4'b0110; ps = 2'b01; dn = 1; pw = az; end
            4'd9:  begin ps = 2'b10; pw = 1; dn = 1; end
            4'd10: begin sa = 1; sb = 2'b10; alu = 4'b0010; end
            4'd11: begin rw = 1; dn = 1; end
            default: ;
        endcase
        return {alu, sa, sb, pw, ps, io, mrd, mwr, irw, rw, rd, m2r, dn, ill};
    endfunction

    task automatic step(input int sel, input logic [3:0] es, input logic mrdy,
                        input logic [5:0] op, input logic [5:0] fn, input logic az,
                        input logic r);
        logic [18:0] obs;
        logic [18:0] ex;
        logic [3:0]  st;
        @(negedge clk);
        rst = r;
        mem_ready = mrdy;
        opcode = op;
        funct = fn;
        alu_zero = az;
        cyc++;
        #1;
        if (r) begin
            total++;
            assert ((o0 & SMASK) === 19'd0) else begin
                bad++;
                $error("FAIL rst_strobes0 cyc %0d: got %b want 0", cyc, o0 & SMASK);
            end
            total++;
            assert ((o1 & SMASK) === 19'd0) else begin
                bad++;
                $error("FAIL rst_strobes1 cyc %0d: got %b want 0", cyc, o1 & SMASK);
            end
        end else begin
            obs = (sel == 1) ? o1 : o0;
            st  = (sel == 1) ? st1 : st0;
            ex  = exp_out(es, mrdy, az, op, fn);
            total++;
            assert (st === es) else begin
                bad++;
                $error("FAIL state dut%0d cyc %0d: got %0d want %0d", sel, cyc, st, es);
            end
            total++;
            assert (obs === ex) else begin
                bad++;
                $error("FAIL outputs dut%0d cyc %0d state %0d: got %b want %b",
                       sel, cyc, es, obs, ex);
            end
        end
    endtask

    // One instruction on dut0: fs fetch stalls, ms data-memory stalls.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic az,
                             input int fs, input int ms);
        repeat (fs) step(0, 4'd0, 1'b0, 6'($urandom), fn, az, 1'b0);
        step(0, 4'd0, 1'b1, 6'($urandom), fn, az, 1'b0);
        step(0, 4'd1, rb(), op, fn, az, 1'b0);
        case (op)
            6'h00: begin step(0, 4'd6, rb(), op, fn, az, 1'b0); step(0, 4'd7, rb(), op, fn, az, 1'b0); end
            6'h23: begin
                step(0, 4'd2, rb(), op, fn, az, 1'b0);
                repeat (ms) step(0, 4'd3, 1'b0, op, fn, az, 1'b0);
                step(0, 4'd3, 1'b1, op, fn, az, 1'b0);
                step(0, 4'd4, rb(), op, fn, az, 1'b0);
            end
            6'h2B: begin
                step(0, 4'd2, rb(), op, fn, az, 1'b0);
                repeat (ms) step(0, 4'd5, 1'b0, op, fn, az, 1'b0);
                step(0, 4'd5, 1'b1, op, fn, az, 1'b0);
            end
            6'h04: step(0, 4'd8, rb(), op, fn, az, 1'b0);
            6'h02: step(0, 4'd9, rb(), op, fn, az, 1'b0);
            6'h08: begin step(0, 4'd10, rb(), op, fn, az, 1'b0); step(0, 4'd11, rb(), op, fn, az, 1'b0); end
            default: ;
        endcase
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] fns [9];
        logic [5:0] op, fn;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h18, 6'h1A, 6'h24, 6'h25, 6'h2A, 6'h3F, 6'h00};

        step(0, 4'd0, 1'b1, 6'h00, 6'h00, 1'b0, 1'b1);
        step(0, 4'd0, 1'b1, 6'h00, 6'h00, 1'b0, 1'b1);

        run_instr(6'h23, 6'h00, 1'b0, 0, 0);
        run_instr(6'h00, 6'h2A, 1'b0, 0, 0);
        run_instr(6'h00, 6'h3F, 1'b0, 0, 0);
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);
        run_instr(6'h04, 6'h00, 1'b0, 0, 0);
        run_instr(6'h2B, 6'h00, 1'b0, 0, 3);
        run_instr(6'h02, 6'h00, 1'b0, 2, 0);
        run_instr(6'h08, 6'h00, 1'b0, 0, 0);
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0);

        // Reset in the middle of a read stall.
        step(0, 4'd0, 1'b1, 6'h11, 6'h00, 1'b0, 1'b0);
        step(0, 4'd1, 1'b1, 6'h23, 6'h00, 1'b0, 1'b0);
        step(0, 4'd2, 1'b1, 6'h23, 6'h00, 1'b0, 1'b0);
        step(0, 4'd3, 1'b0, 6'h23, 6'h00, 1'b0, 1'b0);
        step(0, 4'd3, 1'b0, 6'h23, 6'h00, 1'b0, 1'b0);
        step(0, 4'd0, 1'b0, 6'h23, 6'h00, 1'b0, 1'b1);
        step(0, 4'd0, 1'b0, 6'h23, 6'h00, 1'b0, 1'b1);
        run_instr(6'h00, 6'h22, 1'b0, 1, 0);

        for (int i = 0; i < 80; i++) begin
            op = ops[$urandom_range(6)];
            if ($urandom_range(9) == 0) op = 6'($urandom);
            fn = fns[$urandom_range(8)];
            run_instr(op, fn, rb(), int'($urandom_range(2)), int'($urandom_range(3)));
        end
        step(0, 4'd0, 1'b1, 6'h00, 6'h00, 1'b0, 1'b0);

        // Trapping variant: illegal opcode parks in HALT until reset.
        step(0, 4'd0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b1);
        step(0, 4'd0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b1);
        step(1, 4'd0, 1'b1, 6'h00, 6'h00, 1'b0, 1'b0);
        step(1, 4'd1, 1'b1, 6'h3F, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1, 4'd15, rb(), 6'($urandom), 6'($urandom), rb(), 1'b0);
        step(1, 4'd15, 1'b1, 6'h00, 6'h00, 1'b1, 1'b1);
        step(1, 4'd0, 1'b1, 6'h00, 6'h00, 1'b0, 1'b0);
        step(1, 4'd1, 1'b1, 6'h02, 6'h00, 1'b0, 1'b0);
        step(1, 4'd9, 1'b0, 6'h02, 6'h00, 1'b0, 1'b0);
        step(1, 4'd0, 1'b0, 6'h02, 6'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
